// File: rtl/char_lcd_ctrl_param_if.sv
// Front-end event strobes and HD44780 write-only pin bundle for char_lcd_ctrl_param.
// master: Morse decoder / keypad side; slave: the LCD controller.
interface char_lcd_ctrl_param_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic [1:0] row_sel;
    logic       scroll_up;
    logic       clear;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output char_in, char_valid, row_sel, scroll_up, clear,
        input  busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  char_in, char_valid, row_sel, scroll_up, clear,
        output busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
endinterface

// File: rtl/char_lcd_ctrl_param.sv
// ROWS x COLS character frame buffer with full-panel HD44780 repaint on change.
// Optional LCD_CURSOR_EN: cursor-on init and a trailing cursor-position command per frame.
module char_lcd_ctrl_param #(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 16,
    parameter int unsigned CMD_CYCLES = 2000,
    parameter int unsigned EN_START   = 1000,
    parameter int unsigned EN_LEN     = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    char_lcd_ctrl_param_if.slave  bus
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = $clog2(COLS + 1);
    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned SW = $clog2(CMD_CYCLES);

`ifdef LCD_CURSOR_EN
    typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, SET_ROW, WRITE_ROW, CURSOR, IDLE} state_t;
    localparam logic [7:0] DISP_ON = 8'h0E;
`else
    typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, SET_ROW, WRITE_ROW, IDLE} state_t;
    localparam logic [7:0] DISP_ON = 8'h0C;
`endif

    logic [7:0]    fb_q  [ROWS][COLS];
    logic [CW-1:0] cnt_q [ROWS];
    logic          dirty_q;
    logic          clear_prev, scroll_prev, char_prev;
    logic          clr_ev, scr_ev, chr_ev, sel_ok, start_frame;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [RW-1:0] row_q, row_d;
    logic [XW-1:0] col_q, col_d;
    logic [7:0]    data_q, slot_byte;
    logic          rs_q, slot_rs, en_q;

    function automatic logic [7:0] row_addr(input logic [RW-1:0] r);
        logic [7:0] a;
        a = 8'h00;
        if (32'(r) == 1)      a = 8'h40;
        else if (32'(r) == 2) a = 8'(COLS);
        else if (32'(r) == 3) a = 8'(64 + COLS);
        return a;
    endfunction

    assign clr_ev      = bus.clear & ~clear_prev;
    assign scr_ev      = bus.scroll_up & ~scroll_prev;
    assign chr_ev      = bus.char_valid & ~char_prev;
    assign sel_ok      = 32'(bus.row_sel) < ROWS;
    assign start_frame = (state_q == IDLE) && dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) fb_q[r][c] <= 8'h20;
                cnt_q[r] <= '0;
            end
            dirty_q     <= 1'b0;
            clear_prev  <= 1'b0;
            scroll_prev <= 1'b0;
            char_prev   <= 1'b0;
        end else begin
            clear_prev  <= bus.clear;
            scroll_prev <= bus.scroll_up;
            char_prev   <= bus.char_valid;
            // a change landing on the same edge as the frame start still re-arms dirty
            if (start_frame) dirty_q <= 1'b0;
            if (clr_ev) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    for (int unsigned c = 0; c < COLS; c++) fb_q[r][c] <= 8'h20;
                    cnt_q[r] <= '0;
                end
                dirty_q <= 1'b1;
            end else if (scr_ev) begin
                for (int unsigned r = 0; r + 1 < ROWS; r++) begin
                    for (int unsigned c = 0; c < COLS; c++) fb_q[r][c] <= fb_q[r+1][c];
                    cnt_q[r] <= cnt_q[r+1];
                end
                for (int unsigned c = 0; c < COLS; c++) fb_q[ROWS-1][c] <= 8'h20;
                cnt_q[ROWS-1] <= '0;
                dirty_q <= 1'b1;
            end else if (chr_ev && sel_ok) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    if (32'(bus.row_sel) == r) begin
                        if (bus.char_in == 8'h08) begin
                            if (cnt_q[r] != '0) begin
                                for (int unsigned c = 0; c < COLS; c++)
                                    if (CW'(c) == cnt_q[r] - 1'b1) fb_q[r][c] <= 8'h20;
                                cnt_q[r] <= cnt_q[r] - 1'b1;
                                dirty_q  <= 1'b1;
                            end
                        end else if (cnt_q[r] < CW'(COLS)) begin
                            for (int unsigned c = 0; c < COLS; c++)
                                if (CW'(c) == cnt_q[r]) fb_q[r][c] <= bus.char_in;
                            cnt_q[r] <= cnt_q[r] + 1'b1;
                            dirty_q  <= 1'b1;
                        end else begin
                            for (int unsigned c = 0; c + 1 < COLS; c++) fb_q[r][c] <= fb_q[r][c+1];
                            fb_q[r][COLS-1] <= bus.char_in;
                            dirty_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef LCD_CURSOR_EN
    logic [RW-1:0] cur_row_q;
    logic [CW-1:0] sel_cnt, cur_cnt;
    logic [7:0]    cur_col;
    logic          chr_accept;

    assign sel_cnt    = cnt_q[bus.row_sel[RW-1:0]];
    assign chr_accept = chr_ev && sel_ok && !clr_ev && !scr_ev &&
                        !(bus.char_in == 8'h08 && sel_cnt == '0);
    assign cur_cnt    = cnt_q[cur_row_q];
    assign cur_col    = (cur_cnt >= CW'(COLS - 1)) ? 8'(COLS - 1) : 8'(cur_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cur_row_q <= '0;
        else if (clr_ev)     cur_row_q <= '0;
        else if (chr_accept) cur_row_q <= bus.row_sel[RW-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        row_d   = row_q;
        col_d   = col_q;
        if (state_q == IDLE) begin
            slot_d = '0;
            if (dirty_q) begin
                state_d = SET_ROW;
                row_d   = '0;
                col_d   = '0;
            end
        end else if (slot_q != SW'(CMD_CYCLES - 1)) begin
            slot_d = slot_q + 1'b1;
        end else begin
            slot_d = '0;
            case (state_q)
                INIT0: state_d = INIT1;
                INIT1: state_d = INIT2;
                INIT2: state_d = INIT3;
                INIT3: begin
                    state_d = SET_ROW;
                    row_d   = '0;
                end
                SET_ROW: begin
                    state_d = WRITE_ROW;
                    col_d   = '0;
                end
                WRITE_ROW: begin
                    if (col_q != XW'(COLS - 1)) begin
                        col_d = col_q + 1'b1;
                    end else if (row_q != RW'(ROWS - 1)) begin
                        state_d = SET_ROW;
                        row_d   = row_q + 1'b1;
                    end else begin
`ifdef LCD_CURSOR_EN
                        state_d = CURSOR;
`else
                        state_d = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        slot_byte = 8'h00;
        slot_rs   = 1'b0;
        case (state_q)
            INIT0:     slot_byte = 8'h38;
            INIT1:     slot_byte = DISP_ON;
            INIT2:     slot_byte = 8'h01;
            INIT3:     slot_byte = 8'h06;
            SET_ROW:   slot_byte = 8'h80 | row_addr(row_q);
            WRITE_ROW: begin
                slot_byte = fb_q[row_q][col_q];
                slot_rs   = 1'b1;
            end
`ifdef LCD_CURSOR_EN
            CURSOR:    slot_byte = 8'h80 | (row_addr(cur_row_q) + cur_col);
`endif
            default:   slot_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT0;
            slot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
            col_q   <= col_d;
            // bus byte sampled once per slot, long before the enable pulse
            if (state_q != IDLE && slot_q == '0) begin
                data_q <= slot_byte;
                rs_q   <= slot_rs;
            end
            en_q <= (state_d != IDLE) && (slot_d >= SW'(EN_START)) &&
                    (slot_d < SW'(EN_START + EN_LEN));
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = en_q;
    assign bus.lcd_data = data_q;
endmodule

// File: tb/tb_char_lcd_ctrl_param.sv
// Scoreboard bench for char_lcd_ctrl_param: a 2x16 and a 4x20 instance with short bus slots.
// Expected bus bytes come from a frame-buffer model; each lcd_en rise pops one entry.
module tb_char_lcd_ctrl_param;
    localparam int CMD = 20;
    localparam int ENS = 10;
    localparam int ENL = 4;
`ifdef LCD_CURSOR_EN
    localparam int INIT_SLOTS = 4 + 2 * 17 + 1;
`else
    localparam int INIT_SLOTS = 4 + 2 * 17;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, sel;
    logic [7:0] char_in;
    logic       char_valid, scroll_up, clear;
    logic [1:0] row_sel;

    char_lcd_ctrl_param_if if_a ();
    char_lcd_ctrl_param_if if_b ();

    assign if_a.char_in = char_in;  assign if_b.char_in = char_in;
    assign if_a.char_valid = char_valid;  assign if_b.char_valid = char_valid;
    assign if_a.row_sel = row_sel;  assign if_b.row_sel = row_sel;
    assign if_a.scroll_up = scroll_up;  assign if_b.scroll_up = scroll_up;
    assign if_a.clear = clear;  assign if_b.clear = clear;

    char_lcd_ctrl_param #(.ROWS(2), .COLS(16), .CMD_CYCLES(CMD), .EN_START(ENS), .EN_LEN(ENL))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a));
    char_lcd_ctrl_param #(.ROWS(4), .COLS(20), .CMD_CYCLES(CMD), .EN_START(ENS), .EN_LEN(ENL))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b));

    logic       m_en, m_rs, m_rw, m_busy;
    logic [7:0] m_data;
    always_comb begin
        m_en   = sel ? if_b.lcd_en   : if_a.lcd_en;
        m_rs   = sel ? if_b.lcd_rs   : if_a.lcd_rs;
        m_rw   = sel ? if_b.lcd_rw   : if_a.lcd_rw;
        m_busy = sel ? if_b.busy     : if_a.busy;
        m_data = sel ? if_b.lcd_data : if_a.lcd_data;
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // frame-buffer model
    int         m_rows, m_cols, m_last;
    logic [7:0] mdl [4][20];
    int         m_cnt [4];

    function automatic void m_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 20; c++) mdl[r][c] = 8'h20;
            m_cnt[r] = 0;
        end
        m_last = 0;
    endfunction

    function automatic void m_char(input int r, input logic [7:0] ch);
        if (r < m_rows) begin
            if (ch == 8'h08) begin
                if (m_cnt[r] > 0) begin
                    m_cnt[r]--;
                    mdl[r][m_cnt[r]] = 8'h20;
                    m_last = r;
                end
            end else if (m_cnt[r] < m_cols) begin
                mdl[r][m_cnt[r]] = ch;
                m_cnt[r]++;
                m_last = r;
            end else begin
                for (int c = 0; c < m_cols - 1; c++) mdl[r][c] = mdl[r][c+1];
                mdl[r][m_cols-1] = ch;
                m_last = r;
            end
        end
    endfunction

    function automatic void m_scroll();
        for (int r = 0; r < m_rows - 1; r++) begin
            for (int c = 0; c < m_cols; c++) mdl[r][c] = mdl[r+1][c];
            m_cnt[r] = m_cnt[r+1];
        end
        for (int c = 0; c < m_cols; c++) mdl[m_rows-1][c] = 8'h20;
        m_cnt[m_rows-1] = 0;
    endfunction

    function automatic int addr(input int r);
        case (r)
            1:       return 'h40;
            2:       return m_cols;
            3:       return 'h40 + m_cols;
            default: return 0;
        endcase
    endfunction

    function automatic void push_init();
        exp_q.push_back(9'h038);
`ifdef LCD_CURSOR_EN
        exp_q.push_back(9'h00E);
`else
        exp_q.push_back(9'h00C);
`endif
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endfunction

    function automatic void push_rows();
        for (int r = 0; r < m_rows; r++) begin
            exp_q.push_back(9'('h80 | addr(r)));
            for (int c = 0; c < m_cols; c++) exp_q.push_back({1'b1, mdl[m_last == m_last ? r : r][c]});
        end
    endfunction

    function automatic void push_cursor();
        int col;
        col = (m_cnt[m_last] < m_cols - 1) ? m_cnt[m_last] : m_cols - 1;
        exp_q.push_back(9'('h80 | (addr(m_last) + col)));
    endfunction

    function automatic void push_frame();
        push_rows();
`ifdef LCD_CURSOR_EN
        push_cursor();
`endif
    endfunction

    // monitor: one scoreboard pop per lcd_en rising edge
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        if (m_en && !en_prev) begin
            n_strobes++;
            check("rw", 32'(m_rw), 0);
            if (exp_q.size() == 0) check("extra_strobe", exp_q.size(), 1);
            else check("bus", {23'd0, m_rs, m_data}, {23'd0, exp_q.pop_front()});
        end
        en_prev = m_en;
    end

    task automatic pulse_char(input int r, input logic [7:0] ch, input int hold);
        @(negedge clk);
        row_sel = 2'(r);
        char_in = ch;
        char_valid = 1'b1;
        repeat (hold) @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((m_busy || exp_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(m_busy), 0);
        repeat (6) @(negedge clk);
        check({tag, "_stay_idle"}, 32'(m_busy), 0);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_strobes(input string tag, input int target);
        int n;
        n = 0;
        while (n_strobes < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n_strobes >= target), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, en_at, busy_at, base, n;
        sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        char_in = 8'h00; char_valid = 1'b0; row_sel = 2'd0; scroll_up = 1'b0; clear = 1'b0;
        m_rows = 2; m_cols = 16; m_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(m_busy), 1);
        check("rst_en", 32'(m_en), 0);
        check("rst_rs", 32'(m_rs), 0);
        check("rst_rw", 32'(m_rw), 0);
        check("rst_data", 32'(m_data), 0);

        // power-up init plus one unconditional frame
        push_init(); push_frame();
        rst_a = 1'b1;
        cyc = 0; en_at = -1; busy_at = -1;
        while (busy_at < 0 && cyc < 50 * CMD) begin
            @(posedge clk); #1;
            cyc++;
            if (en_at < 0 && m_en) en_at = cyc;
            if (!m_busy) busy_at = cyc;
        end
        check("first_en_rise", en_at, ENS);
        check("busy_fall", busy_at, INIT_SLOTS * CMD);
        wait_idle("init");

        // 'S' held high for 5 cycles: one character, repaint starts within 2 edges
        m_char(0, 8'h53); push_frame();
        @(negedge clk);
        row_sel = 2'd0; char_in = 8'h53; char_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("latency_busy", 32'(m_busy), 1);
        repeat (4) @(negedge clk);
        char_valid = 1'b0;
        wait_idle("char_S");

        m_char(1, 8'h4F); push_frame();
        pulse_char(1, 8'h4F, 1);
        wait_idle("char_O");

        // 17 chars to row 1 in a burst: row 1 is read after the burst, then one follow-up
        for (int i = 0; i < 17; i++) m_char(1, 8'(8'h41 + i));
        push_frame(); push_frame();
        for (int i = 0; i < 17; i++) pulse_char(1, 8'(8'h41 + i), 1);
        wait_idle("overflow");

        m_char(1, 8'h08); push_frame();
        pulse_char(1, 8'h08, 1);
        wait_idle("backspace");

        pulse_char(2, 8'h58, 1);
        wait_idle("bad_row");

        // clear, scroll_up and char_valid on the same edge: clear wins
        m_reset(); push_frame();
        @(negedge clk);
        clear = 1'b1; scroll_up = 1'b1; char_valid = 1'b1; char_in = 8'h51; row_sel = 2'd0;
        @(negedge clk);
        clear = 1'b0; scroll_up = 1'b0; char_valid = 1'b0;
        wait_idle("priority");

        pulse_char(0, 8'h08, 1);
        wait_idle("bs_empty");

        // change to row 0 after row 0 was sent: old row 0 now, new row 0 in the follow-up
        base = n_strobes;
        m_char(1, 8'h58); push_rows();
        pulse_char(1, 8'h58, 1);
        wait_strobes("mid_wait", base + 18);
        m_char(0, 8'h59);
`ifdef LCD_CURSOR_EN
        push_cursor();
`endif
        push_frame();
        pulse_char(0, 8'h59, 1);
        wait_idle("mid_frame");

        // reset pulse during a strobe
        base = n_strobes;
        m_char(0, 8'h52); push_frame();
        pulse_char(0, 8'h52, 1);
        wait_strobes("rst_wait", base + 5);
        n = 0;
        while (!m_en && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_en_seen", 32'(m_en), 1);
        rst_a = 1'b0;
        #1;
        check("rst_mid_en", 32'(m_en), 0);
        check("rst_mid_rs", 32'(m_rs), 0);
        check("rst_mid_data", 32'(m_data), 0);
        check("rst_mid_busy", 32'(m_busy), 1);
        exp_q.delete();
        m_reset(); push_init(); push_frame();
        @(negedge clk);
        rst_a = 1'b1;
        wait_idle("rst_mid");

        // 4x20 instance
        @(negedge clk);
        rst_a = 1'b0; sel = 1'b1;
        m_rows = 4; m_cols = 20; m_reset();
        push_init(); push_frame();
        rst_b = 1'b1;
        wait_idle("b_init");

        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 3; i++) m_char(r, 8'(8'h61 + 3 * r + i));
        push_frame(); push_frame();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 3; i++) pulse_char(r, 8'(8'h61 + 3 * r + i), 1);
        wait_idle("b_fill");

        m_scroll(); push_frame();
        @(negedge clk); scroll_up = 1'b1;
        @(negedge clk); scroll_up = 1'b0;
        wait_idle("b_scroll");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
